// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/stall controller: state encoding,
// NOP instruction word and hold/flush polarities.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StMdWait  = 2'd2
  } state_e;

  // addi x0, x0, 0 -- what a flushed pipeline register is loaded with
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam logic Hold   = 1'b1;
  localparam logic Pass   = 1'b0;
  localparam logic FlushN = 1'b0;
  localparam logic KeepN  = 1'b1;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID
// instruction reads.
module hazard_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  output logic       hazard_o
);

  assign hazard_o = ex_mem_read_i & (ex_rd_i != 5'd0) &
                    ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                     (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait, mul/div-wait and load-use
// hazards, with a memory timeout abort and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_md_start,
  input  logic        md_done,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        hold_pc,
  output logic        hold_if_id,
  output logic        hold_id_ex,
  output logic        hold_ex_mem,
  output logic        flush_if_id_n,
  output logic        flush_id_ex_n,
  output logic        flush_ex_mem_n,
  output logic        flush_mem_wb_n,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_seen_q, done_seen_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        hazard;
  logic        mstall;
  logic        run_rules;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .hazard_o      (hazard)
  );

  assign mstall    = mem_req & ~mem_ack;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    done_seen_d    = done_seen_q;
    redir_pend_d   = redir_pend_q;
    run_rules      = 1'b0;
    hold_pc        = Pass;
    hold_if_id     = Pass;
    hold_id_ex     = Pass;
    hold_ex_mem    = Pass;
    flush_if_id_n  = KeepN;
    flush_id_ex_n  = KeepN;
    flush_ex_mem_n = KeepN;
    flush_mem_wb_n = KeepN;
    mem_timeout    = 1'b0;

    unique case (state_q)
      StRun: run_rules = 1'b1;
      StMemWait: begin
        if (mem_ack) begin
          run_rules = 1'b1;
        end else if (cnt_q == TimeoutCnt) begin
          mem_timeout    = 1'b1;
          flush_if_id_n  = FlushN;
          flush_id_ex_n  = FlushN;
          flush_ex_mem_n = FlushN;
          flush_mem_wb_n = FlushN;
          state_d        = StRun;
        end else begin
          {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem} = {4{Hold}};
          flush_mem_wb_n = FlushN;
          cnt_d          = cnt_q + 8'd1;
        end
      end
      StMdWait: begin
        if (mstall) begin
          {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem} = {4{Hold}};
          flush_mem_wb_n = FlushN;
          // Remember a completion that arrived while MEM was blocked
          if (md_done) done_seen_d = 1'b1;
        end else if (md_done || done_seen_q) begin
          run_rules   = 1'b1;
          done_seen_d = 1'b0;
        end else begin
          {hold_pc, hold_if_id, hold_id_ex} = {3{Hold}};
          flush_ex_mem_n = FlushN;
        end
      end
      default: state_d = StRun;
    endcase

    if (run_rules) begin
      state_d = StRun;
      if (mstall) begin
        {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem} = {4{Hold}};
        flush_mem_wb_n = FlushN;
        state_d        = StMemWait;
        cnt_d          = 8'd0;
      end else if (ex_md_start) begin
        // Redirect is deferred to the MD_WAIT exit cycle
        {hold_pc, hold_if_id, hold_id_ex} = {3{Hold}};
        flush_ex_mem_n = FlushN;
        state_d        = StMdWait;
        redir_pend_d   = redir_pend_q | ex_redirect;
      end else begin
        redir_pend_d = 1'b0;
        if (ex_redirect || redir_pend_q) begin
          flush_if_id_n = FlushN;
          flush_id_ex_n = FlushN;
        end else if (hazard) begin
          hold_pc       = Hold;
          hold_if_id    = Hold;
          flush_id_ex_n = FlushN;
        end
      end
    end

    if (rst) begin
      hold_pc        = Pass;
      hold_if_id     = Pass;
      hold_id_ex     = Pass;
      hold_ex_mem    = Pass;
      flush_if_id_n  = KeepN;
      flush_id_ex_n  = KeepN;
      flush_ex_mem_n = KeepN;
      flush_mem_wb_n = KeepN;
      mem_timeout    = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (hold_pc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      cnt_q        <= 8'd0;
      done_seen_q  <= 1'b0;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_seen_q  <= done_seen_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed hold/flush patterns
// and stall counts; built with a short memory timeout.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic        ex_md_start, md_done, mem_req, mem_ack;
  logic        hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
  logic        flush_if_id_n, flush_id_ex_n, flush_ex_mem_n, flush_mem_wb_n;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [8:0]  outs;

  int n_vec = 0;
  int n_err = 0;

  // {holds pc,if_id,id_ex,ex_mem, flush_n if_id,id_ex,ex_mem,mem_wb, timeout}
  localparam logic [8:0] OIdle = 9'b0000_1111_0;
  localparam logic [8:0] OLu   = 9'b1100_1011_0;
  localparam logic [8:0] ORed  = 9'b0000_0011_0;
  localparam logic [8:0] OMs   = 9'b1111_1110_0;
  localparam logic [8:0] OMd   = 9'b1110_1101_0;
  localparam logic [8:0] OTo   = 9'b0000_0000_1;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_redirect    (ex_redirect),
    .ex_md_start    (ex_md_start),
    .md_done        (md_done),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .hold_pc        (hold_pc),
    .hold_if_id     (hold_if_id),
    .hold_id_ex     (hold_id_ex),
    .hold_ex_mem    (hold_ex_mem),
    .flush_if_id_n  (flush_if_id_n),
    .flush_id_ex_n  (flush_id_ex_n),
    .flush_ex_mem_n (flush_ex_mem_n),
    .flush_mem_wb_n (flush_mem_wb_n),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt)
  );

  assign outs = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem,
                 flush_if_id_n, flush_id_ex_n, flush_ex_mem_n, flush_mem_wb_n, mem_timeout};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic lu_rs1(input logic [4:0] r);
    ex_mem_read = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
  endtask

  // Inputs are already driven; sample mid-cycle, then advance to next cycle.
  task automatic step(input string tag, input logic [8:0] exp_o, input logic [31:0] exp_cnt);
    @(negedge clk);
    check_eq({tag, "_out"}, {23'd0, outs}, {23'd0, exp_o});
    check_eq({tag, "_cnt"}, stall_cnt, exp_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    $display("pipe_ctrl bench, nop word %h", NopInstr);
    clr();
    rst = 1'b1;
    mem_req = 1'b1;
    #3;
    check_eq("rst_out", {23'd0, outs}, {23'd0, OIdle});
    check_eq("rst_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();

    step("idle", OIdle, 0);
    lu_rs1(5'd5);                                   step("lu_rs1", OLu, 0);
    clr();                                          step("lu_after", OIdle, 1);
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
                                                    step("lu_rs2", OLu, 1);
    clr();                                          step("idle2", OIdle, 2);
    lu_rs1(5'd0);                                   step("rd_zero", OIdle, 2);
    lu_rs1(5'd5); id_use_rs1 = 1'b0;                step("no_use", OIdle, 2);
    lu_rs1(5'd5); ex_mem_read = 1'b0;               step("no_load", OIdle, 2);
    lu_rs1(5'd5); ex_redirect = 1'b1;               step("redir_haz", ORed, 2);
    clr();                                          step("redir_cnt", OIdle, 2);

    // memory wait, three stalled cycles then ack
    mem_req = 1'b1;                                 step("mw0", OMs, 2);
    ex_redirect = 1'b1; lu_rs1(5'd3);               step("mw1_ignore", OMs, 3);
    clr(); mem_req = 1'b1;                          step("mw2", OMs, 4);
    mem_ack = 1'b1;                                 step("mw_ack", OIdle, 5);
    clr(); lu_rs1(5'd9);                            step("mw_run", OLu, 5);
    clr();                                          step("mw_done", OIdle, 6);

    // timeout: entry cycle plus four MEM_WAIT cycles, then abort
    mem_req = 1'b1;
    step("to0", OMs, 6);
    step("to1", OMs, 7);
    step("to2", OMs, 8);
    step("to3", OMs, 9);
    step("to4", OMs, 10);
    step("to_pulse", OTo, 11);
    step("to_single", OMs, 11);
    mem_ack = 1'b1;                                 step("to_ack", OIdle, 12);
    clr();                                          step("to_idle", OIdle, 12);

    // mul/div with deferred redirect and done during mstall
    ex_md_start = 1'b1; ex_redirect = 1'b1; md_done = 1'b1;
                                                    step("md_start", OMd, 12);
    clr();                                          step("md_wait", OMd, 13);
    mem_req = 1'b1; md_done = 1'b1;                 step("md_mstall", OMs, 14);
    md_done = 1'b0; mem_ack = 1'b1;                 step("md_exit", ORed, 15);
    clr();                                          step("md_run", OIdle, 15);
    ex_md_start = 1'b1;                             step("md2_start", OMd, 15);
    clr(); md_done = 1'b1;                          step("md2_exit", OIdle, 16);
    clr();                                          step("md2_run", OIdle, 16);

    // reset in the middle of a memory wait
    mem_req = 1'b1;
    step("rw0", OMs, 16);
    step("rw1", OMs, 17);
    rst = 1'b1;
    #1;
    check_eq("rw_rst_out", {23'd0, outs}, {23'd0, OIdle});
    check_eq("rw_rst_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    step("rw_run", OIdle, 0);
    step("rw_run2", OIdle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
